adder_share_arbiter: RTL and testbench

- Shares one WIDTH-bit binary adder between NUM_REQ requesters.
- Requesters post operand pairs over valid/ready. A round-robin arbiter grants one pair per cycle.
- The sum is registered and returned with the requester ID over a valid/ready response port.
- Replaces per-consumer adder instances in the top-level accumulate datapath.

---
 rtl/adder_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one WIDTH-bit adder between NUM_REQ requesters. A round-robin
// arbiter picks at most one operand pair per cycle; the sum is registered
// and presented with the requester index on a valid/ready response port.
// Optional build macro ADDER_ARB_CARRY_EN adds a registered rsp_carry output
// holding the carry-out of the add; without it the carry is dropped.
module adder_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 5,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
`ifdef ADDER_ARB_CARRY_EN
    output logic                     rsp_carry,
`endif
    output logic [WIDTH-1:0]         rsp_sum
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [WIDTH-1:0]    rsp_sum_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic                can_accept;
    logic                accept;
    logic [WIDTH-1:0]    sum_d;

    // Modulo-2^WIDTH sum; the carry is intentionally lost.
    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

`ifdef ADDER_ARB_CARRY_EN
    logic                rsp_carry_q;
    logic                carry_d;

    // Carry-out of the WIDTH-bit add, computed one bit wider.
    function automatic logic add_carry(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[WIDTH];
    endfunction
`endif

    // Round-robin search starting at rr_ptr; also muxes the winner's operands.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            automatic int idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
                sel_a       = req_a[idx*WIDTH +: WIDTH];
                sel_b       = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a new sum when empty or being drained
    // this cycle; nothing is accepted while reset is asserted.
    assign can_accept = (state_q == IDLE) || rsp_ready;
    assign accept     = can_accept && grant_found && !reset;

    // One-hot ready toward the granted requester only.
    always_comb begin
        req_ready            = '0;
        req_ready[grant_idx] = accept;
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ-1 for any count.
    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx + 1'b1;
        end
    end

    assign sum_d = add_mod(sel_a, sel_b);
`ifdef ADDER_ARB_CARRY_EN
    assign carry_d = add_carry(sel_a, sel_b);
`endif

    // Response FSM: capture on accept, drain to IDLE when emptied with no new grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rr_ptr_q    <= '0;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= 1'b0;
`endif
        end else if (accept) begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx;
            rsp_sum_q   <= sum_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= carry_d;
`endif
        end else if (state_q == HOLD && rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
`ifdef ADDER_ARB_CARRY_EN
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed testbench for adder_share_arbiter (NUM_REQ=4, WIDTH=5).
// Carry-output checks are compiled in when ADDER_ARB_CARRY_EN is defined.
module tb_adder_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 5;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
`ifdef ADDER_ARB_CARRY_EN
    logic                     rsp_carry;
`endif

    int n_cmp;
    int n_bad;

    adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef ADDER_ARB_CARRY_EN
        .rsp_carry (rsp_carry),
`endif
        .rsp_sum   (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b id=%0d sum=%0d want v=0 id=0 sum=0",
                     rsp_valid, rsp_id, rsp_sum);
        end
`ifdef ADDER_ARB_CARRY_EN
        n_cmp++;
        if (rsp_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_carry: got %b want 0", rsp_carry);
        end
`endif
        req_valid = '0;
        reset     = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 3, 4);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 5'd7) begin
            n_bad++;
            $display("FAIL single_rsp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=7",
                     rsp_valid, rsp_id, rsp_sum);
        end
`ifdef ADDER_ARB_CARRY_EN
        n_cmp++;
        if (rsp_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL single_carry: got %b want 0", rsp_carry);
        end
`endif
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, i, 10);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
            end
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(k % 4) || rsp_sum !== WIDTH'(10 + k % 4)) begin
                n_bad++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                         k, rsp_valid, rsp_id, rsp_sum, k % 4, 10 + k % 4);
            end
        end
        req_valid = '0;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(2, 4, 5);
        set_op(0, 1, 1);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
            end
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 5'd9) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d want v=1 id=2 sum=9",
                         c, rsp_valid, rsp_id, rsp_sum);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL bp_release_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 5'd2) begin
            n_bad++;
            $display("FAIL bp_next_rsp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=2",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

    task automatic test_wrap_carry();
        do_reset();
        set_op(0, 31, 1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        step();
        set_op(1, 20, 20);
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 5'd0) begin
            n_bad++;
            $display("FAIL wrap_31p1: got v=%b id=%0d sum=%0d want v=1 id=0 sum=0",
                     rsp_valid, rsp_id, rsp_sum);
        end
`ifdef ADDER_ARB_CARRY_EN
        n_cmp++;
        if (rsp_carry !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_31p1: got %b want 1", rsp_carry);
        end
`endif
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_b2b_ready: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'd8) begin
            n_bad++;
            $display("FAIL wrap_20p20: got v=%b id=%0d sum=%0d want v=1 id=1 sum=8",
                     rsp_valid, rsp_id, rsp_sum);
        end
`ifdef ADDER_ARB_CARRY_EN
        n_cmp++;
        if (rsp_carry !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_20p20: got %b want 1", rsp_carry);
        end
`endif
        step();
    endtask

    task automatic test_pointer();
        do_reset();
        set_op(3, 1, 2);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL ptr_ready3: got %b want 1000", req_ready);
        end
        step();
        set_op(0, 5, 6);
        set_op(2, 7, 8);
        req_valid = 4'b0101;
        #1;
        n_cmp++;
        if (rsp_id !== 2'd3 || rsp_sum !== 5'd3) begin
            n_bad++;
            $display("FAIL ptr_rsp3: got id=%0d sum=%0d want id=3 sum=3", rsp_id, rsp_sum);
        end
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL ptr_wrap_ready: got %b want 0001", req_ready);
        end
        step();
        #1;
        n_cmp++;
        if (rsp_id !== 2'd0 || rsp_sum !== 5'd11) begin
            n_bad++;
            $display("FAIL ptr_rsp0: got id=%0d sum=%0d want id=0 sum=11", rsp_id, rsp_sum);
        end
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL ptr_ready2: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 5'd15) begin
            n_bad++;
            $display("FAIL ptr_rsp2: got v=%b id=%0d sum=%0d want v=1 id=2 sum=15",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        set_op(1, 2, 3);
        set_op(2, 9, 9);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'd5) begin
            n_bad++;
            $display("FAIL mid_hold_pre: got v=%b id=%0d sum=%0d want v=1 id=1 sum=5",
                     rsp_valid, rsp_id, rsp_sum);
        end
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_hold_ready_in_reset: got %b want 0000", req_ready);
        end
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_hold_cleared: got v=%b id=%0d sum=%0d want v=0 id=0 sum=0",
                     rsp_valid, rsp_id, rsp_sum);
        end
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL mid_hold_first_grant: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'd5) begin
            n_bad++;
            $display("FAIL mid_hold_post_rsp: got v=%b id=%0d sum=%0d want v=1 id=1 sum=5",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_carry();
        test_pointer();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
